// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder.
// Holds opcode constants, the NOP word, instruction field widths and the
// encoder FSM state encoding.
package cpu_isa_pkg;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int WORD_W  = 32;
  localparam int PAD_W   = 8;   // width of the NOP pad counter

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BGT   = 6'b000111;
  localparam logic [OP_W-1:0] OP_BNEZ  = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGEZ  = 6'b000001;

  // AND r0,r0,r0
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_PAD  = 2'd2
  } enc_state_t;

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BNEZ) || (op == OP_BGEZ);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer.
// Inputs : op, rs, rt, rd, funct, imm  -- raw instruction fields
// Outputs: word  -- encoded 32-bit instruction
//          valid -- opcode is supported
//          pad   -- number of NOPs that must follow this instruction
module instr_field_pack
  import cpu_isa_pkg::*;
#(
  parameter int BR_PAD = 3,
  parameter int LW_PAD = 1
) (
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm,
  output logic [WORD_W-1:0]  word,
  output logic               valid,
  output logic [PAD_W-1:0]   pad
);

  always_comb begin
    word  = '0;
    valid = 1'b0;
    pad   = '0;
    case (op)
      OP_RTYPE: begin
        word  = {op, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
        valid = 1'b1;
      end
      OP_ADDI, OP_ORI, OP_SW: begin
        word  = {op, rs, rt, imm};
        valid = 1'b1;
      end
      OP_BEQ, OP_BGT, OP_BNEZ, OP_BGEZ: begin
        word  = {op, rs, rt, imm};
        valid = 1'b1;
        pad   = PAD_W'(BR_PAD);
      end
      OP_LW: begin
        word  = {op, rs, rt, imm};
        valid = 1'b1;
        pad   = PAD_W'(LW_PAD);
      end
      default: begin
        word  = '0;
        valid = 1'b0;
        pad   = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instruction requests, packs them into
// 32-bit words and streams them into instruction memory, inserting NOPs after
// branches and loads.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   req_valid_i/req_ready_o handshake with fields req_op_i, req_rs_i,
//   req_rt_i, req_rd_i, req_funct_i, req_imm_i
//   im_we_o/im_addr_o/im_data_o  registered memory write port
//   err_o  sticky unsupported-opcode flag, full_o  sticky memory-full flag
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int IM_WORDS = 128,
  parameter int BR_PAD   = 3,
  parameter int LW_PAD   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [OP_W-1:0]    req_op_i,
  input  logic [REG_W-1:0]   req_rs_i,
  input  logic [REG_W-1:0]   req_rt_i,
  input  logic [REG_W-1:0]   req_rd_i,
  input  logic [FUNCT_W-1:0] req_funct_i,
  input  logic [IMM_W-1:0]   req_imm_i,
  output logic               im_we_o,
  output logic [31:0]        im_addr_o,
  output logic [WORD_W-1:0]  im_data_o,
  output logic               err_o,
  output logic               full_o
);

  // One extra bit so the word pointer can hold IM_WORDS after the last write.
  localparam int PTR_W = $clog2(IM_WORDS) + 1;

  enc_state_t           state_reg, state_next;
  logic [PAD_W-1:0]     pad_cnt_reg, pad_cnt_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic                 we_reg, we_next;
  logic [31:0]          addr_reg, addr_next;
  logic [WORD_W-1:0]    data_reg, data_next;
  logic                 err_reg, err_next;
  logic                 full_reg, full_next;

  logic [WORD_W-1:0]    pk_word;
  logic                 pk_valid;
  logic [PAD_W-1:0]     pk_pad;
  logic                 accept;
  logic                 last_word;

  instr_field_pack #(
    .BR_PAD (BR_PAD),
    .LW_PAD (LW_PAD)
  ) u_pack (
    .op    (req_op_i),
    .rs    (req_rs_i),
    .rt    (req_rt_i),
    .rd    (req_rd_i),
    .funct (req_funct_i),
    .imm   (req_imm_i),
    .word  (pk_word),
    .valid (pk_valid),
    .pad   (pk_pad)
  );

  // Gated by rst_i so the encoder never advertises ready while held in reset.
  assign req_ready_o = rst_i && (state_reg == ST_IDLE) && !full_reg;
  assign accept      = req_valid_i && req_ready_o;
  // The write currently being scheduled targets the final memory word.
  assign last_word   = (ptr_reg == PTR_W'(IM_WORDS - 1));

  always_comb begin
    state_next   = state_reg;
    pad_cnt_next = pad_cnt_reg;
    ptr_next     = ptr_reg;
    we_next      = 1'b0;
    addr_next    = addr_reg;
    data_next    = data_reg;
    err_next     = err_reg;
    full_next    = full_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EMIT;
          if (pk_valid) begin
            we_next      = 1'b1;
            data_next    = pk_word;
            addr_next    = 32'({ptr_reg, 2'b00});
            ptr_next     = ptr_reg + 1'b1;
            full_next    = full_reg | last_word;
            pad_cnt_next = pk_pad;
          end else begin
            // Unsupported opcode: consumed with no write and no address step.
            err_next     = 1'b1;
            pad_cnt_next = '0;
          end
        end
      end
      ST_EMIT, ST_PAD: begin
        // full_reg already reflects the write shown this cycle, so pads stop
        // as soon as the final word has been written.
        if ((pad_cnt_reg != '0) && !full_reg) begin
          state_next   = ST_PAD;
          we_next      = 1'b1;
          data_next    = NOP_WORD;
          addr_next    = 32'({ptr_reg, 2'b00});
          ptr_next     = ptr_reg + 1'b1;
          full_next    = full_reg | last_word;
          pad_cnt_next = pad_cnt_reg - 1'b1;
        end else begin
          state_next   = ST_IDLE;
          pad_cnt_next = '0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        pad_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg   <= ST_IDLE;
      pad_cnt_reg <= '0;
      ptr_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
      full_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pad_cnt_reg <= pad_cnt_next;
      ptr_reg     <= ptr_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      full_reg    <= full_next;
    end
  end

  assign im_we_o   = we_reg;
  assign im_addr_o = addr_reg;
  assign im_data_o = data_reg;
  assign err_o     = err_reg;
  assign full_o    = full_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default-size instance for the main
// encoding/padding/reset cases and a 4-word instance for the memory-full case.
module tb_instr_encoder;
  import cpu_isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst4;
  logic        req_valid, valid4;
  logic        ready, ready4;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        we, we4;
  logic [31:0] addr, addr4, data, data4;
  logic        err, err4, full, full4;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  logic [63:0] q4[$];

  instr_encoder dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
    .req_op_i(op), .req_rs_i(rs), .req_rt_i(rt), .req_rd_i(rd),
    .req_funct_i(funct), .req_imm_i(imm),
    .im_we_o(we), .im_addr_o(addr), .im_data_o(data), .err_o(err), .full_o(full)
  );

  instr_encoder #(.IM_WORDS(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .req_valid_i(valid4), .req_ready_o(ready4),
    .req_op_i(op), .req_rs_i(rs), .req_rt_i(rt), .req_rd_i(rd),
    .req_funct_i(funct), .req_imm_i(imm),
    .im_we_o(we4), .im_addr_o(addr4), .im_data_o(data4), .err_o(err4), .full_o(full4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every write strobe.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", addr, data);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        $display("write  addr=%h data=%h (exp %h %h)", addr, data, e[63:32], e[31:0]);
        chk("wr_addr", addr, e[63:32]);
        chk("wr_data", data, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (we4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write4: got addr=%h data=%h expected no write", addr4, data4);
      end else begin
        logic [63:0] e;
        e = q4.pop_front();
        $display("write4 addr=%h data=%h (exp %h %h)", addr4, data4, e[63:32], e[31:0]);
        chk("wr4_addr", addr4, e[63:32]);
        chk("wr4_data", data4, e[31:0]);
      end
    end
  end

  // Issue one request; when exp_low >= 0, count cycles with ready low afterwards.
  task automatic send(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                      input int exp_low, input string name);
    int n;
    @(negedge clk);
    chk({name, "_ready"}, {31'b0, ready}, 32'd1);
    op = o; rs = s; rt = t; rd = d; funct = f; imm = i;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    $display("send   %s op=%b rs=%0d rt=%0d rd=%0d funct=%h imm=%h", name, o, s, t, d, f, i);
    if (exp_low >= 0) begin
      n = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (ready === 1'b1) break;
        n++;
      end
      chk({name, "_busy_cycles"}, n, exp_low);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n4;
    rst = 1'b0; rst4 = 1'b0; req_valid = 1'b0; valid4 = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_we",    {31'b0, we},    32'd0);
    chk("rst_addr",  addr,           32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_full",  {31'b0, full},  32'd0);
    rst = 1'b1;
    #1 chk("release_ready", {31'b0, ready}, 32'd1);

    q.push_back({32'd0, 32'h2022_0005});
    send(OP_ADDI, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 1, "addi");
    q.push_back({32'd4, 32'h0022_1820});
    send(OP_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1, "rtype");

    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;

    q.push_back({32'd0,  32'h1022_FFFE});
    q.push_back({32'd4,  NOP_WORD});
    q.push_back({32'd8,  NOP_WORD});
    q.push_back({32'd12, NOP_WORD});
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFE, 4, "beq");

    q.push_back({32'd16, 32'h8C04_0008});
    q.push_back({32'd20, NOP_WORD});
    send(OP_LW, 5'd0, 5'd4, 5'd0, 6'h00, 16'h0008, 2, "lw");

    send(6'b111111, 5'd1, 5'd1, 5'd1, 6'h00, 16'h1234, 1, "bad_op");
    chk("bad_op_err", {31'b0, err}, 32'd1);

    q.push_back({32'd24, 32'h3465_00FF});
    send(OP_ORI, 5'd3, 5'd5, 5'd0, 6'h00, 16'h00FF, 1, "ori");
    q.push_back({32'd28, 32'hAC43_0004});
    send(OP_SW, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0004, 1, "sw");

    q.push_back({32'd32, 32'h04E0_0010});
    q.push_back({32'd36, NOP_WORD});
    q.push_back({32'd40, NOP_WORD});
    q.push_back({32'd44, NOP_WORD});
    send(OP_BGEZ, 5'd7, 5'd0, 5'd0, 6'h00, 16'h0010, 4, "bgez");

    q.push_back({32'd48, 32'h1C22_0003});
    q.push_back({32'd52, NOP_WORD});
    q.push_back({32'd56, NOP_WORD});
    q.push_back({32'd60, NOP_WORD});
    send(OP_BGT, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0003, 4, "bgt");

    // Reset asserted during the second PAD cycle: the NOP at 72 is already
    // on the bus, the final NOP at 76 must be abandoned.
    q.push_back({32'd64, 32'h1480_FFF0});
    q.push_back({32'd68, NOP_WORD});
    q.push_back({32'd72, NOP_WORD});
    send(OP_BNEZ, 5'd4, 5'd0, 5'd0, 6'h00, 16'hFFF0, -1, "bnez_rst");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("midpad_rst_we",    {31'b0, we},    32'd0);
    chk("midpad_rst_addr",  addr,           32'd0);
    chk("midpad_rst_err",   {31'b0, err},   32'd0);
    chk("midpad_rst_full",  {31'b0, full},  32'd0);
    chk("midpad_rst_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    #1 chk("midpad_idle_ready", {31'b0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    // Four-word memory: a branch fills it exactly, then nothing is accepted.
    rst4 = 1'b1;
    q4.push_back({32'd0,  32'h1022_FFFE});
    q4.push_back({32'd4,  NOP_WORD});
    q4.push_back({32'd8,  NOP_WORD});
    q4.push_back({32'd12, NOP_WORD});
    @(negedge clk);
    chk("im4_ready", {31'b0, ready4}, 32'd1);
    op = OP_BEQ; rs = 5'd1; rt = 5'd2; rd = 5'd0; funct = 6'h00; imm = 16'hFFFE;
    valid4 = 1'b1;
    @(posedge clk);
    #1 valid4 = 1'b0;
    $display("send   im4_beq op=%b imm=%h", op, imm);
    repeat (6) @(negedge clk);
    chk("im4_full", {31'b0, full4}, 32'd1);
    op = OP_ADDI; imm = 16'h0001;
    valid4 = 1'b1;
    n4 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready4 !== 1'b0) n4++;
    end
    valid4 = 1'b0;
    chk("im4_ready_high_cycles", n4, 32'd0);
    chk("queue4_empty", q4.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
